// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// A three-state FSM (IDLE/RUN/DONE) sequences WIDTH add steps and pulses done for one cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] srb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    // The single adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    assign {fa_c, fa_s} = full_add(sra[0], srb[0], carry);
    assign last         = (cnt == LAST);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    // Written as shift-then-insert so WIDTH=1 needs no special case.
    always_comb begin
        acc_nxt            = acc >> 1;
        acc_nxt[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sra   <= '0;
            srb   <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sra   <= a;
                        srb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    sra   <= sra >> 1;
                    srb   <= srb >> 1;
                    acc   <= acc_nxt;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum  <= acc_nxt;
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8, 1 and 16.
// Every expected result is a hand value or computed here with native arithmetic.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
    logic [0:0]  a1 = '0, b1 = '0, sum1;
    logic        start16 = 1'b0, cin16 = 1'b0, busy16, done16, cout16;
    logic [15:0] a16 = '0, b16 = '0, sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );
    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one WIDTH=8 op, scramble operands after acceptance, wait for done.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        lat = 0;
        tick();
        start8 = 1'b0; a8 = ~a; b8 = a ^ 8'h5A; cin8 = ~c;
        lat = 1;
        while (!done8 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic op1(input logic [0:0] a, input logic [0:0] b, input logic c, output int lat);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        tick();
        start1 = 1'b0; a1 = ~a; b1 = ~b;
        lat = 1;
        while (!done1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        tick();
        start16 = 1'b0; a16 = ~a; b16 = ~b;
        lat = 1;
        while (!done16 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          pulses;
        int          last_done;
        int          gap_bad;
        int          sum_bad;
        int          spurious;
        logic [7:0]  hold_sum;
        logic [1:0]  e1;
        logic [16:0] e16;

        // Reset, with start asserted alongside it: reset must win.
        rst = 1'b1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        tick(); tick();
        rst = 1'b0; start8 = 1'b0;
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_sum",  32'(sum8),  32'd0);
        chk("reset_cout", 32'(cout8), 32'd0);
        tick();
        chk("rst_start_idle", 32'(busy8), 32'd0);

        // 1: basic add and latency.
        op8(8'h35, 8'h4A, 1'b0, lat);
        chk("t1_latency", 32'(lat), 32'd9);
        chk("t1_sum",  32'(sum8),  32'h7F);
        chk("t1_cout", 32'(cout8), 32'd0);
        tick();
        chk("t1_done_pulse_one_cycle", 32'(done8), 32'd0);
        chk("t1_idle_after", 32'(busy8), 32'd0);
        chk("t1_sum_held", 32'(sum8), 32'h7F);

        // 2: carry-out cases.
        op8(8'hFF, 8'h01, 1'b0, lat);
        chk("t2a_sum",  32'(sum8),  32'h00);
        chk("t2a_cout", 32'(cout8), 32'd1);
        tick();
        op8(8'hFF, 8'hFF, 1'b1, lat);
        chk("t2b_sum",  32'(sum8),  32'hFF);
        chk("t2b_cout", 32'(cout8), 32'd1);
        tick();

        // 3: start re-pulsed during RUN is ignored.
        a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1; start8 = 1'b1;
        tick(); tick();
        chk("t3_busy_mid", 32'(busy8), 32'd1);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            chk("t3_busy_until_done", 32'(busy8), 32'd1);
            tick();
            lat++;
        end
        chk("t3_done_seen", 32'(done8), 32'd1);
        chk("t3_sum",  32'(sum8),  32'h7F);
        chk("t3_cout", 32'(cout8), 32'd0);
        tick();

        // 4: reset four cycles into RUN aborts with no done pulse.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_busy", 32'(busy8), 32'd0);
        chk("t4_done", 32'(done8), 32'd0);
        chk("t4_sum",  32'(sum8),  32'd0);
        chk("t4_cout", 32'(cout8), 32'd0);
        spurious = 0;
        repeat (12) begin
            tick();
            if (done8 || busy8) spurious++;
        end
        chk("t4_no_done_after_abort", 32'(spurious), 32'd0);
        op8(8'h12, 8'h34, 1'b0, lat);
        chk("t4_after_sum",  32'(sum8),  32'h46);
        chk("t4_after_cout", 32'(cout8), 32'd0);
        chk("t4_after_latency", 32'(lat), 32'd9);
        tick();

        // 5: start held high for 40 cycles -> back-to-back ops every WIDTH+2 cycles.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
        hold_sum = 8'h46;
        pulses = 0; last_done = 0; gap_bad = 0; sum_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done8) begin
                if (pulses == 0 && i != 9) gap_bad++;
                if (pulses > 0 && i - last_done != 10) gap_bad++;
                pulses++;
                last_done = i;
                hold_sum = 8'h31;
            end
            if (sum8 !== hold_sum) sum_bad++;
        end
        start8 = 1'b0;
        chk("t5_pulses", 32'(pulses), 32'd4);
        chk("t5_spacing", 32'(gap_bad), 32'd0);
        chk("t5_sum_stable", 32'(sum8 == hold_sum ? sum_bad : sum_bad + 1), 32'd0);
        chk("t5_final_sum", 32'(sum8), 32'h31);
        tick(); tick();
        chk("t5_idle", 32'(busy8), 32'd0);

        // 6a: WIDTH=1 random.
        for (int i = 0; i < 500; i++) begin
            logic [0:0] ra, rb;
            logic       rc;
            ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
            e1 = {1'b0, ra} + {1'b0, rb} + {1'b0, rc};
            op1(ra, rb, rc, lat);
            chk("w1_result", 32'({cout1, sum1}), 32'(e1));
            chk("w1_latency", 32'(lat), 32'd2);
            tick();
        end

        // 6b: WIDTH=16 random.
        for (int i = 0; i < 500; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            e16 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            op16(ra, rb, rc, lat);
            chk("w16_result", 32'({cout16, sum16}), 32'(e16));
            chk("w16_latency", 32'(lat), 32'd17);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
